// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared defaults and types for the 1rw1r SRAM arbiter.
// Optional statistics outputs are enabled with SRAM_ARB_STATS_EN.
package sram_arb_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;
  localparam int RD_LAT         = 2;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B
  } owner_t;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v,
    input logic        inc
  );
    return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction
endpackage

// File: rtl/sram_arb_rr2.sv
// sram_arb_rr2: two-way round-robin grant with a registered pointer.
// Pointer moves to the loser only on contended grants.
module sram_arb_rr2 (
  input  logic clk,
  input  logic rstb,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  logic ptr_q, ptr_d;

  // ptr_q = 0 favours A, 1 favours B
  always_comb begin
    gnt_a = req_a & (~req_b | ~ptr_q);
    gnt_b = req_b & (~req_a | ptr_q);
    ptr_d = ptr_q;
    if (req_a & req_b) ptr_d = gnt_a;
  end

  always_ff @(posedge clk) begin
    if (!rstb) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/sram_1rw1r_arbiter.sv
// sram_1rw1r_arbiter: A/B round-robin on RW port 0, C on R port 1.
// Macro SRAM_ARB_STATS_EN adds saturating grant/collision counters.
module sram_1rw1r_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
  input  logic                  clk0,
  input  logic                  rstb,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [NUM_WMASKS-1:0] a_wmask,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [NUM_WMASKS-1:0] b_wmask,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  input  logic                  c_valid,
  output logic                  c_ready,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  output logic                  c_rsp_valid,
  output logic [DATA_WIDTH-1:0] c_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]           stat_grants_a,
  output logic [15:0]           stat_grants_b,
  output logic [15:0]           stat_collisions
`endif
);
  logic                  gnt_a, gnt_b, p0_go, c_go;
  logic                  sel_we, coll;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [NUM_WMASKS-1:0] sel_wmask;
  owner_t                iss_own;

  logic                  csb0_q, csb0_d, web0_q, web0_d;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic                  csb1_q, csb1_d;
  owner_t [RD_LAT-1:0]   own_q, own_d;
  logic   [RD_LAT-1:0]   ctag_q, ctag_d;
  logic                  a_rv_q, a_rv_d, b_rv_q, b_rv_d;
  logic                  c_rv_q, c_rv_d;
  logic [DATA_WIDTH-1:0] a_rd_q, a_rd_d, b_rd_q, b_rd_d;
  logic [DATA_WIDTH-1:0] c_rd_q, c_rd_d;

  sram_arb_rr2 u_rr (
    .clk   (clk0),
    .rstb  (rstb),
    .req_a (a_valid),
    .req_b (b_valid),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  always_comb begin
    a_ready   = rstb & gnt_a;
    b_ready   = rstb & gnt_b;
    p0_go     = a_ready | b_ready;
    sel_we    = gnt_a ? a_we    : b_we;
    sel_addr  = gnt_a ? a_addr  : b_addr;
    sel_wdata = gnt_a ? a_wdata : b_wdata;
    sel_wmask = gnt_a ? a_wmask : b_wmask;
    // C waits one cycle so it reads the post-write word
    coll      = p0_go & sel_we & c_valid & (c_addr == sel_addr);
    c_ready   = rstb & ~coll;
    c_go      = c_valid & c_ready;
    iss_own   = OWN_NONE;
    if (a_ready & ~a_we)      iss_own = OWN_A;
    else if (b_ready & ~b_we) iss_own = OWN_B;
  end

  always_comb begin
    csb0_d   = ~p0_go;
    web0_d   = web0_q;
    wmask0_d = wmask0_q;
    addr0_d  = addr0_q;
    din0_d   = din0_q;
    if (p0_go) begin
      web0_d   = ~sel_we;
      wmask0_d = sel_wmask;
      addr0_d  = sel_addr;
      din0_d   = sel_wdata;
    end
    csb1_d  = ~c_go;
    addr1_d = c_go ? c_addr : addr1_q;
    own_d[0]  = iss_own;
    ctag_d[0] = c_go;
    for (int i = 1; i < RD_LAT; i++) begin
      own_d[i]  = own_q[i-1];
      ctag_d[i] = ctag_q[i-1];
    end
    a_rv_d = own_q[RD_LAT-1] == OWN_A;
    b_rv_d = own_q[RD_LAT-1] == OWN_B;
    c_rv_d = ctag_q[RD_LAT-1];
    a_rd_d = a_rv_d ? dout0 : a_rd_q;
    b_rd_d = b_rv_d ? dout0 : b_rd_q;
    c_rd_d = c_rv_d ? dout1 : c_rd_q;
  end

  always_ff @(posedge clk0) begin
    if (!rstb) begin
      csb0_q   <= 1'b1;
      web0_q   <= 1'b1;
      wmask0_q <= '0;
      addr0_q  <= '0;
      din0_q   <= '0;
      csb1_q   <= 1'b1;
      addr1_q  <= '0;
      own_q    <= {RD_LAT{OWN_NONE}};
      ctag_q   <= '0;
      a_rv_q   <= 1'b0;
      b_rv_q   <= 1'b0;
      c_rv_q   <= 1'b0;
      a_rd_q   <= '0;
      b_rd_q   <= '0;
      c_rd_q   <= '0;
    end else begin
      csb0_q   <= csb0_d;
      web0_q   <= web0_d;
      wmask0_q <= wmask0_d;
      addr0_q  <= addr0_d;
      din0_q   <= din0_d;
      csb1_q   <= csb1_d;
      addr1_q  <= addr1_d;
      own_q    <= own_d;
      ctag_q   <= ctag_d;
      a_rv_q   <= a_rv_d;
      b_rv_q   <= b_rv_d;
      c_rv_q   <= c_rv_d;
      a_rd_q   <= a_rd_d;
      b_rd_q   <= b_rd_d;
      c_rd_q   <= c_rd_d;
    end
  end

  assign csb0        = csb0_q;
  assign web0        = web0_q;
  assign wmask0      = wmask0_q;
  assign addr0       = addr0_q;
  assign din0        = din0_q;
  assign csb1        = csb1_q;
  assign addr1       = addr1_q;
  assign a_rsp_valid = a_rv_q;
  assign b_rsp_valid = b_rv_q;
  assign c_rsp_valid = c_rv_q;
  assign a_rdata     = a_rd_q;
  assign b_rdata     = b_rd_q;
  assign c_rdata     = c_rd_q;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] sga_q, sga_d, sgb_q, sgb_d, scol_q, scol_d;

  always_comb begin
    sga_d  = sat_inc16(sga_q, a_ready);
    sgb_d  = sat_inc16(sgb_q, b_ready);
    scol_d = sat_inc16(scol_q, coll);
  end

  always_ff @(posedge clk0) begin
    if (!rstb) begin
      sga_q  <= '0;
      sgb_q  <= '0;
      scol_q <= '0;
    end else begin
      sga_q  <= sga_d;
      sgb_q  <= sgb_d;
      scol_q <= scol_d;
    end
  end

  assign stat_grants_a   = sga_q;
  assign stat_grants_b   = sgb_q;
  assign stat_collisions = scol_q;
`endif
endmodule

// File: tb/tb_sram_1rw1r_arbiter.sv
// tb_sram_1rw1r_arbiter: directed stimulus with queued expectations.
// Includes a behavioural 1rw1r macro; SRAM_ARB_STATS_EN adds stat checks.
module tb_sram_1rw1r_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MW = 4;

  logic          clk0 = 1'b0;
  logic          rstb = 1'b0;
  logic          a_valid = 0, a_we = 0, b_valid = 0, b_we = 0;
  logic          c_valid = 0;
  logic [MW-1:0] a_wmask = '0, b_wmask = '0;
  logic [AW-1:0] a_addr = '0, b_addr = '0, c_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_ready, b_ready, c_ready;
  logic          a_rsp_valid, b_rsp_valid, c_rsp_valid;
  logic [DW-1:0] a_rdata, b_rdata, c_rdata;
  logic          csb0, web0, csb1;
  logic [MW-1:0] wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, dout0, dout1;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0]   stat_grants_a, stat_grants_b, stat_collisions;
`endif

  sram_1rw1r_arbiter dut (
    .clk0(clk0), .rstb(rstb),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we),
    .a_wmask(a_wmask), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we),
    .b_wmask(b_wmask), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rdata(b_rdata),
    .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr),
    .c_rsp_valid(c_rsp_valid), .c_rdata(c_rdata),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0),
    .csb1(csb1), .addr1(addr1), .dout1(dout1)
`ifdef SRAM_ARB_STATS_EN
    ,
    .stat_grants_a(stat_grants_a),
    .stat_grants_b(stat_grants_b),
    .stat_collisions(stat_collisions)
`endif
  );

  always #5 clk0 = ~clk0;

  // behavioural macro: sample at posedge, access at negedge
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          p0_en, p0_wr, p1_en;
  logic [AW-1:0] p0_a, p1_a;
  logic [DW-1:0] p0_d;
  logic [MW-1:0] p0_m;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    dout0 = '0;
    dout1 = '0;
  end

  always @(posedge clk0) begin
    p0_en <= (csb0 == 1'b0);
    p0_wr <= (web0 == 1'b0);
    p0_a  <= addr0;
    p0_d  <= din0;
    p0_m  <= wmask0;
    p1_en <= (csb1 == 1'b0);
    p1_a  <= addr1;
  end

  // port 1 reads before the port-0 write so an unstalled clash sees old data
  always @(negedge clk0) begin
    if (p1_en) dout1 = mem[p1_a];
    if (p0_en && p0_wr)
      for (int k = 0; k < MW; k++)
        if (p0_m[k]) mem[p0_a][8*k +: 8] = p0_d[8*k +: 8];
    if (p0_en && !p0_wr) dout0 = mem[p0_a];
  end

  int cyc = 0;
  always @(posedge clk0) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;
  exp_t qa[$], qb[$], qc[$];
  int   glog[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cyc %0d)", nm, cyc);
  endtask

  always @(posedge clk0) begin
    if (a_valid && a_ready) glog.push_back(0);
    else if (b_valid && b_ready) glog.push_back(1);
  end

  // monitor: pop expectation on each response pulse, flag late ones
  always @(negedge clk0) begin
    exp_t e;
    if (a_rsp_valid) begin
      if (qa.size() == 0) miss("a_unexpected_rsp");
      else begin
        e = qa.pop_front();
        chk("a_rdata", a_rdata, e.d);
        chk("a_latency", cyc, e.c);
      end
    end else if (qa.size() != 0 && qa[0].c <= cyc) begin
      void'(qa.pop_front());
      miss("a_missing_rsp");
    end
    if (b_rsp_valid) begin
      if (qb.size() == 0) miss("b_unexpected_rsp");
      else begin
        e = qb.pop_front();
        chk("b_rdata", b_rdata, e.d);
        chk("b_latency", cyc, e.c);
      end
    end else if (qb.size() != 0 && qb[0].c <= cyc) begin
      void'(qb.pop_front());
      miss("b_missing_rsp");
    end
    if (c_rsp_valid) begin
      if (qc.size() == 0) miss("c_unexpected_rsp");
      else begin
        e = qc.pop_front();
        chk("c_rdata", c_rdata, e.d);
        chk("c_latency", cyc, e.c);
      end
    end else if (qc.size() != 0 && qc[0].c <= cyc) begin
      void'(qc.pop_front());
      miss("c_missing_rsp");
    end
  end

  // requesters start and end at a negedge; a read pushes data and due cycle
  task automatic a_req(input logic we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd, input logic [MW-1:0] wm,
                       input logic [DW-1:0] ex);
    int n = 0;
    a_valid = 1'b1; a_we = we; a_addr = ad; a_wdata = wd; a_wmask = wm;
    #1;
    while (!a_ready && n < 20) begin @(negedge clk0); #1; n++; end
    if (!a_ready) miss("a_ready_timeout");
    else if (!we) qa.push_back('{ex, cyc + 3});
    @(posedge clk0);
    @(negedge clk0);
    a_valid = 1'b0;
  endtask

  task automatic b_req(input logic we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd, input logic [MW-1:0] wm,
                       input logic [DW-1:0] ex);
    int n = 0;
    b_valid = 1'b1; b_we = we; b_addr = ad; b_wdata = wd; b_wmask = wm;
    #1;
    while (!b_ready && n < 20) begin @(negedge clk0); #1; n++; end
    if (!b_ready) miss("b_ready_timeout");
    else if (!we) qb.push_back('{ex, cyc + 3});
    @(posedge clk0);
    @(negedge clk0);
    b_valid = 1'b0;
  endtask

  task automatic c_req(input logic [AW-1:0] ad, input logic [DW-1:0] ex);
    int n = 0;
    c_valid = 1'b1; c_addr = ad;
    #1;
    while (!c_ready && n < 20) begin @(negedge clk0); #1; n++; end
    if (!c_ready) miss("c_ready_timeout");
    else qc.push_back('{ex, cyc + 3});
    @(posedge clk0);
    @(negedge clk0);
    c_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_expired (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq;
    // reset with every requester asserting
    rstb = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1;
    repeat (2) @(negedge clk0);
    #1;
    chk("rst_ready", {a_ready, b_ready, c_ready}, 3'b000);
    chk("rst_csb", {csb0, csb1, web0}, 3'b111);
    chk("rst_addr0", addr0, 0);
    chk("rst_din0", din0, 0);
    chk("rst_wmask0", wmask0, 0);
    chk("rst_addr1", addr1, 0);
    chk("rst_rsp", {a_rsp_valid, b_rsp_valid, c_rsp_valid}, 3'b000);
    chk("rst_rdata", a_rdata | b_rdata | c_rdata, 0);
    @(negedge clk0);
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    rstb = 1'b1;
    idle(1);

    // A write then read back
    a_req(1'b1, 10'h005, 32'hDEADBEEF, 4'hF, '0);
    a_req(1'b0, 10'h005, '0, '0, 32'hDEADBEEF);
    idle(4);

    // contended reads alternate A,B,A,B
    a_req(1'b1, 10'h001, 32'h0000_1111, 4'hF, '0);
    b_req(1'b1, 10'h002, 32'h0000_2222, 4'hF, '0);
    glog.delete();
    fork
      begin
        a_req(1'b0, 10'h001, '0, '0, 32'h0000_1111);
        a_req(1'b0, 10'h001, '0, '0, 32'h0000_1111);
      end
      begin
        b_req(1'b0, 10'h002, '0, '0, 32'h0000_2222);
        b_req(1'b0, 10'h002, '0, '0, 32'h0000_2222);
      end
    join
    chk("rr_count", glog.size(), 4);
    seq = '0;
    foreach (glog[i]) seq = {seq[2:0], glog[i][0]};
    chk("rr_order", seq, 4'b0101);
    idle(4);

    // partial byte mask
    a_req(1'b1, 10'h020, 32'h11223344, 4'hF, '0);
    a_req(1'b1, 10'h020, 32'hAABBCCDD, 4'b0101, '0);
    a_req(1'b1, 10'h020, 32'hFFFFFFFF, 4'b0000, '0);
    a_req(1'b0, 10'h020, '0, '0, 32'h11BB33DD);
    idle(4);

    // B write vs C read on the same address
    fork
      b_req(1'b1, 10'h3FF, 32'hCAFEF00D, 4'hF, '0);
      c_req(10'h3FF, 32'hCAFEF00D);
      begin #1; chk("coll_c_ready", c_ready, 1'b0); end
    join
    idle(4);

    // reset while an A read is in flight
    a_req(1'b0, 10'h005, '0, '0, 32'hDEADBEEF);
    rstb = 1'b0;
    qa.delete();
    a_valid = 1'b1; c_valid = 1'b1;
    @(negedge clk0);
    #1;
    chk("midrst_csb", {csb0, csb1}, 2'b11);
    chk("midrst_ready", {a_ready, c_ready}, 2'b00);
    @(negedge clk0);
    chk("midrst_no_rsp", a_rsp_valid, 1'b0);
    a_valid = 1'b0; c_valid = 1'b0;
    rstb = 1'b1;
    idle(1);

    // 3 A grants, 2 B grants, 1 collision
    a_req(1'b0, 10'h005, '0, '0, 32'hDEADBEEF);
    a_req(1'b0, 10'h020, '0, '0, 32'h11BB33DD);
    b_req(1'b0, 10'h3FF, '0, '0, 32'hCAFEF00D);
    b_req(1'b0, 10'h001, '0, '0, 32'h0000_1111);
    fork
      a_req(1'b1, 10'h3FE, 32'h5555AAAA, 4'hF, '0);
      c_req(10'h3FE, 32'h5555AAAA);
    join
    idle(4);
`ifdef SRAM_ARB_STATS_EN
    chk("stat_grants_a", stat_grants_a, 16'd3);
    chk("stat_grants_b", stat_grants_b, 16'd2);
    chk("stat_collisions", stat_collisions, 16'd1);
`endif

    idle(4);
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    chk("drain_c", qc.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_1rw1r_arbiter.md
Name: sram_1rw1r_arbiter

Overview:
- Shares the 32x1024 1rw1r SRAM macro between three requesters: A and B (read/write) round-robin on the RW port 0, C (read-only) on the R port 1.
- Drives all macro pins from flops, tracks in-flight reads and routes read data back to the issuing requester with fixed latency.
- Detects write/read same-address collisions between the ports and stalls C for them.
- Sits between the core-side bus adapters and the macro. Macro clk0/clk1 are tied to this block's clock at the top level.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 10, word address width.
- NUM_WMASKS, 4, byte write-mask width (DATA_WIDTH/8).

Ports:
- clk0  in  1  single clock; also drives macro clk0/clk1.
- rstb  in  1  synchronous active-low reset.
- a_valid, b_valid  in  1  request valid.
- a_ready, b_ready  out  1  request accepted this cycle.
- a_we, b_we  in  1  1=write, 0=read.
- a_wmask, b_wmask  in  NUM_WMASKS  byte enables (writes only).
- a_addr, b_addr  in  ADDR_WIDTH  word address.
- a_wdata, b_wdata  in  DATA_WIDTH  write data.
- a_rsp_valid, b_rsp_valid  out  1  read data valid (one-cycle pulse).
- a_rdata, b_rdata  out  DATA_WIDTH  read data.
- c_valid  in  1  read request valid.
- c_ready  out  1  read request accepted this cycle.
- c_addr  in  ADDR_WIDTH  word address.
- c_rsp_valid  out  1  read data valid pulse.
- c_rdata  out  DATA_WIDTH  read data.
- csb0, web0  out  1  macro port 0 chip select / write enable, active low.
- wmask0  out  NUM_WMASKS  macro port 0 write mask.
- addr0  out  ADDR_WIDTH  macro port 0 address.
- din0  out  DATA_WIDTH  macro port 0 write data.
- dout0  in  DATA_WIDTH  macro port 0 read data.
- csb1  out  1  macro port 1 chip select, active low.
- addr1  out  ADDR_WIDTH  macro port 1 address.
- dout1  in  DATA_WIDTH  macro port 1 read data.

Behaviour:
- Reset (rstb=0 at posedge clk0):
  - csb0=csb1=1, web0=1; wmask0/addr0/din0/addr1 = 0.
  - All rsp_valid=0; rdata regs=0; round-robin pointer=A.
  - In-flight read tags cleared; responses to reads issued before reset are never delivered.
  - Ready outputs are 0 while rstb=0.
- Handshake: a transfer occurs when valid&&ready at a posedge. Readys are combinational from valids and never depend on the requester's own ready. No response backpressure.
- Port 0 arbitration:
  - Only one of A/B valid: that one is granted.
  - Both valid: the pointer selects; after a contended grant the pointer moves to the loser.
  - Uncontended grants leave the pointer unchanged.
- Issue: on a transfer at edge T, the macro pins are registered at T (csb0=0, web0=~we, wmask0, addr0, din0) and held one cycle. With no transfer, csb0=1 at T.
- Read timing: the macro samples at T+1. This block captures dout0 at T+2 into x_rdata and pulses x_rsp_valid during [T+2,T+3). Fixed 2-cycle latency; up to 2 reads in flight per port.
- Writes produce no response. wmask=0 is issued as a write that changes nothing.
- Port 1: c_ready=1 unless collision. Issue and latency match port 0 (csb1/addr1 registered, dout1 captured at T+2).
- Collision: if the port-0 grant this cycle is a write and c_valid && c_addr equals the granted address, c_ready=0.
  - C issues the next cycle and returns the post-write data.
  - A read on port 0 to the same address as C is allowed.
- Read-after-write: a read issued at T+1 after a write transfer at T returns the new data. No forwarding is needed; the macro writes on the negedge.
- Simultaneous read responses on A/B cannot occur (one port-0 issue per cycle). The C response is independent.
- Addresses are used unmodified, no wrap logic. ADDR_WIDTH covers exactly the macro depth.

Optional Feature:
- SRAM_ARB_STATS_EN defined adds three 16-bit outputs, all saturating at 16'hFFFF and cleared by reset:
  - stat_grants_a: count of A transfers.
  - stat_grants_b: count of B transfers.
  - stat_collisions: cycles with c_ready forced low.
- Undefined: the outputs and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sram_arb_pkg:
  - DATA_WIDTH/ADDR_WIDTH/NUM_WMASKS defaults.
  - Read latency constant RD_LAT=2.
  - Enum owner_t {OWN_NONE, OWN_A, OWN_B} for the port-0 in-flight tag pipeline.
- One sub-module: sram_arb_rr2 (2-way round-robin grant with pointer register, synchronous active-low reset).

Test Plan:
- Reset, then A writes addr 10'h005 data 32'hDEADBEEF wmask 4'hF; A reads 10'h005 -> a_rsp_valid exactly 2 cycles after the read transfer, a_rdata=32'hDEADBEEF, b_rsp_valid stays 0.
- A and B both valid reading 10'h001/10'h002 for 4 cycles -> grants alternate A,B,A,B. Each rsp_valid arrives 2 cycles after its grant with the correct word.
- Byte mask: write 32'h11223344 full, then 32'hAABBCCDD wmask 4'b0101, read back -> 32'h11BB33DD.
- Collision: B writes 10'h3FF=32'hCAFEF00D while C reads 10'h3FF in the same cycle -> c_ready=0 that cycle, C issues next cycle, c_rdata=32'hCAFEF00D.
- Reset mid-flight: A read accepted at T, rstb=0 at T+1 -> no a_rsp_valid at T+2; csb0=csb1=1 during reset.
- With SRAM_ARB_STATS_EN: 3 A grants, 2 B grants, 1 collision -> stats 3/2/1. Without the macro, the bench compiles with the stat ports absent.
